// File: rtl/button_event_queue.sv
// Serialises single-cycle button pulses into index codes and buffers them in a
// first-word-fall-through FIFO; any dropped pulse raises a sticky overflow flag.
module button_event_queue #(
  parameter  int unsigned N_BTN = 4,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(N_BTN),
  localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_pulse,
  output logic             ev_valid,
  output logic [CW-1:0]    ev_code,
  input  logic             ev_ready,
  output logic [CNTW-1:0]  ev_count,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);

  logic [N_BTN-1:0] pending;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    mem [DEPTH];

  logic [CW-1:0]    sel;
  logic             push;
  logic             pop;
  logic             drop;
  logic [N_BTN-1:0] clr_vec;
  logic [N_BTN-1:0] pending_kept;

  // Lowest pending index wins the single enqueue slot each cycle.
  always_comb begin
    sel = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (pending[i]) sel = CW'(i);
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  always_comb begin
    push         = (pending != '0) && (ev_count < FULL_COUNT);
    pop          = ev_valid && ev_ready;
    clr_vec      = push ? (N_BTN'(1) << sel) : '0;
    pending_kept = pending & ~clr_vec;
    drop         = (pending_kept & btn_pulse) != '0;
  end

  assign ev_valid = (ev_count != '0);
  assign ev_code  = ev_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_kept | btn_pulse;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   ev_count <= ev_count + CNTW'(1);
        2'b01:   ev_count <= ev_count - CNTW'(1);
        default: ev_count <= ev_count;
      endcase
      // A new drop outranks a clear request in the same cycle.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel;
  end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Downstream consumer of the per-button debouncers.
- Collects single-cycle press/auto-repeat pulses from N_BTN debounced buttons and serialises them into button-index event codes.
- Buffers the codes in a small first-word-fall-through FIFO for the game/menu control FSM.
- Guarantees no pulse is silently lost: a drop always raises a sticky overflow flag.

Parameters:
- N_BTN, 4, number of debounced button inputs (>=2).
- DEPTH, 8, FIFO entries; power of two, >=2.
- CW, $clog2(N_BTN), event code width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- btn_pulse  in  N_BTN  single-cycle pulses from the debouncers; bit i = button i.
- ev_valid  out  1  head entry available.
- ev_code  out  CW  button index at FIFO head; valid only while ev_valid=1.
- ev_ready  in  1  consumer accepts head; pop on ev_valid & ev_ready.
- ev_count  out  $clog2(DEPTH+1)  current number of FIFO entries.
- overflow  out  1  sticky: at least one pulse was dropped.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (rst=1 at a clk edge): pending=0, FIFO empty (wr_ptr=rd_ptr=0), ev_count=0, ev_valid=0, overflow=0, ev_code=0. Reset mid-operation discards all pending and queued events.
- Stage 1, pending register (N_BTN bits):
  - btn_pulse[i]=1 sets pending[i] at the next edge.
  - If pending[i] is already 1, is not being cleared this cycle, and btn_pulse[i]=1, the pulse is dropped and overflow is set.
- Stage 2, selector:
  - Each cycle, if pending != 0 and ev_count < DEPTH, the lowest set index k is written into the FIFO and pending[k] is cleared.
  - Exactly one enqueue per cycle maximum.
  - If btn_pulse[k]=1 in the same cycle pending[k] is cleared, pending[k] stays 1. This is not a drop.
  - When the FIFO is full (ev_count==DEPTH), no enqueue occurs, even if a pop happens that same cycle. Pending bits are held.
- FIFO:
  - FWFT: ev_valid = (ev_count != 0); ev_code = mem[rd_ptr] combinationally.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle: ev_count is unchanged and both pointers advance.
  - ev_ready while ev_valid=0 is ignored.
- Latency: pulse sampled at edge E0 sets pending. If it is the lowest pending bit and the FIFO is not full, it is enqueued at E1, and ev_valid/ev_code reflect it after E1. Minimum is 2 cycles.
- Ordering:
  - Events from different cycles are queued in arrival order, subject to pending priority.
  - Simultaneous pulses are queued lowest index first, one per cycle.
- Overflow:
  - Set by any dropped pulse.
  - clr_overflow=1 clears it at the next edge.
  - If clr_overflow and a new drop occur in the same cycle, set wins (overflow=1).
- No combinational path from btn_pulse to any output.
- ev_ready affects only registered state; ev_valid, ev_code and ev_count depend only on registered state.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then btn_pulse=0 for 10 cycles -> ev_valid=0, ev_count=0, overflow=0 throughout.
- Single event: btn_pulse=4'b0100 for 1 cycle, ev_ready=0 -> 2 edges later ev_valid=1, ev_code=2, ev_count=1. Then ev_ready=1 for 1 cycle -> ev_count=0, ev_valid=0.
- Simultaneous pulses: btn_pulse=4'b1011 for 1 cycle, ev_ready=1 -> consumer receives codes 0, 1, 3 on three consecutive cycles. overflow stays 0.
- Full FIFO and drop, DEPTH=8:
  - Feed 8 single pulses on button 1 with ev_ready=0 -> ev_count=8.
  - Pulse button 1 again -> held in pending, overflow=0.
  - Pulse button 1 again -> overflow=1.
  - Then ev_ready=1 continuously -> exactly 9 code-1 events delivered.
- Wrap and simultaneous push/pop: stream 20 pulses cycling buttons 0..3, one every 3 cycles, with ev_ready=1 -> all 20 codes are delivered in order, ev_count never exceeds 1, and the pointers wrap twice.
- Overflow clear/priority: with overflow=1, assert clr_overflow together with a new drop -> overflow=1. Then assert clr_overflow alone -> overflow=0. Then assert rst while ev_count=5 -> ev_count=0 and pending=0 after the next edge.
